// File: rtl/iter_alu.sv
// Iterative execute ALU: single-cycle base integer ops plus shift-add
// multiply and restoring divide/remainder with RV32M semantics, wrapped
// in valid/ready handshakes on both the operand and the result side.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for operands; base ops and divide-by-zero finish here
// CALC  | one multiply/divide iteration per cycle, cnt = 0 .. WIDTH-1
// DONE  | result/flags held with out_valid until out_ready
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             less,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t               state, state_next;
    logic [SHW-1:0]       cnt;
    logic [2*WIDTH-1:0]   prod;     // mul: {acc, multiplier}; div: {rem, quotient/dividend}
    logic [WIDTH-1:0]     opnd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic [2:0]           mop;
    logic                 neg_a, neg_b;

    logic                 accept, div_zero, sa_in, sb_in;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH-1:0]     base_res;
    logic                 base_less, base_zero;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   iter_next, mul_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, m_res;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);
    assign accept    = in_valid && in_ready;

    // Operand decode: signedness of each operand and its magnitude
    always_comb begin
        sa_in    = op[4] && (op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10)) && a[WIDTH-1];
        sb_in    = op[4] && (op[2] ? !op[0] : (op[1:0] == 2'b01)) && b[WIDTH-1];
        abs_a    = sa_in ? -a : a;
        abs_b    = sb_in ? -b : b;
        div_zero = op[4] && op[2] && (b == '0);
    end

    // Single-cycle base operations and compare flags
    always_comb begin
        base_res  = '0;
        base_less = 1'b0;
        base_zero = 1'b0;
        case (op[2:0])
            3'b000: base_res = op[3] ? (a - b) : (a + b);
            3'b001: base_res = a << b[SHW-1:0];
            3'b010: begin
                if (op[3]) base_less = (a < b);
                else       base_less = ($signed(a) < $signed(b));
                base_zero = (a == b);
                base_res  = base_less ? a : b;
            end
            3'b011: base_res = b;
            3'b100: base_res = a ^ b;
            3'b101: begin
                if (op[3]) base_res = $signed(a) >>> b[SHW-1:0];
                else       base_res = a >> b[SHW-1:0];
            end
            3'b110: base_res = a | b;
            default: base_res = a & b;
        endcase
    end

    // One iteration step and the sign fix applied on the last one
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opnd : '0)};
        div_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} - {1'b0, opnd};
        if (mop[2]) begin
            if (div_trial[WIDTH]) iter_next = prod << 1;
            else                  iter_next = {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end else begin
            iter_next = {mul_sum, prod[WIDTH-1:1]};
        end
        mul_fix = (neg_a ^ neg_b) ? -iter_next : iter_next;
        quo_fix = (neg_a ^ neg_b) ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
        rem_fix = neg_a ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
        case (mop)
            3'b000:         m_res = mul_fix[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         m_res = mul_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: m_res = quo_fix;
            default:        m_res = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (!op[4] || div_zero) ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            less   <= 1'b0;
            zero   <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            opnd   <= '0;
            mop    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!op[4]) begin
                            result <= base_res;
                            less   <= base_less;
                            zero   <= base_zero;
                        end else if (div_zero) begin
                            result <= op[1] ? a : '1;
                            less   <= 1'b0;
                            zero   <= 1'b0;
                        end else begin
                            mop   <= op[2:0];
                            neg_a <= sa_in;
                            neg_b <= sb_in;
                            cnt   <= '0;
                            prod  <= {{WIDTH{1'b0}}, (op[2] ? abs_a : abs_b)};
                            opnd  <= op[2] ? abs_b : abs_a;
                        end
                    end
                end
                CALC: begin
                    prod <= iter_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result <= m_res;
                        less   <= 1'b0;
                        zero   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu (WIDTH=32): directed vectors plus randomized ops
// checked against an arithmetic reference model.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        less, zero, busy;

    int n_vec = 0;
    int n_err = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .less(less), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, SLL = 5'b00001,
                           SRL = 5'b00101, SRA = 5'b01101, XOR = 5'b00100,
                           OR  = 5'b00110, AND = 5'b00111, CMPS = 5'b00010,
                           CMPU = 5'b01010, MUL = 5'b10000, MULH = 5'b10001,
                           MULHU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101,
                           REM = 5'b10110, REMU = 5'b10111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: {less, zero, result}
    function automatic logic [33:0] ref_alu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs, ys, yp, p;
        logic [63:0] xu, yu, pu;
        logic [31:0] r;
        logic lt, eq;
        int sh;
        xs = $signed({{32{x[31]}}, x});
        ys = $signed({{32{y[31]}}, y});
        xu = {32'b0, x};
        yu = {32'b0, y};
        yp = $signed(yu);
        sh = int'(y[4:0]);
        lt = 1'b0;
        eq = 1'b0;
        r  = '0;
        if (!o[4]) begin
            case (o[2:0])
                3'd0: r = o[3] ? x - y : x + y;
                3'd1: r = x << sh;
                3'd2: begin
                    if (o[3]) lt = x < y;
                    else      lt = $signed(x) < $signed(y);
                    eq = (x == y);
                    r  = lt ? x : y;
                end
                3'd3: r = y;
                3'd4: r = x ^ y;
                3'd5: begin
                    if (o[3]) r = $signed(x) >>> sh;
                    else      r = x >> sh;
                end
                3'd6: r = x | y;
                default: r = x & y;
            endcase
        end else begin
            case (o[2:0])
                3'd0: begin p = xs * ys; r = p[31:0]; end
                3'd1: begin p = xs * ys; r = p[63:32]; end
                3'd2: begin p = xs * yp; r = p[63:32]; end
                3'd3: begin pu = xu * yu; r = pu[63:32]; end
                3'd4: begin
                    if (y == 0) r = '1;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                    else begin p = xs / ys; r = p[31:0]; end
                end
                3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
                3'd6: begin
                    if (y == 0) r = x;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
                    else begin p = xs % ys; r = p[31:0]; end
                end
                default: r = (y == 0) ? x : x % y;
            endcase
        end
        return {lt, eq, r};
    endfunction

    // Issue one op, check latency/result/flags, optionally stall in DONE
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic el, input logic ez, input int hold);
        int g, lat, exp_lat;
        g = 0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        chk("in_ready", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        exp_lat = (o[4] && !(o[2] && y == 0)) ? 33 : 1;
        chk("busy", busy, exp_lat > 1);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk("latency", lat, exp_lat);
        chk("result", result, er);
        chk("less", less, el);
        chk("zero", zero, ez);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_result", result, er);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        chk("done_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    task automatic do_rand(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [33:0] m;
        m = ref_alu(o, x, y);
        do_op(o, x, y, m[31:0], m[33], m[32], hold);
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_less", less, 0);
        chk("rst_zero", zero, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        do_op(ADD,  32'h8000_00F0, 32'h4, 32'h8000_00F4, 0, 0, 0);
        do_op(SUB,  32'h8000_00F0, 32'h4, 32'h8000_00EC, 0, 0, 0);
        do_op(SLL,  32'h8000_00F0, 32'h4, 32'h0000_0F00, 0, 0, 0);
        do_op(SRL,  32'h8000_00F0, 32'h4, 32'h0800_000F, 0, 0, 0);
        do_op(SRA,  32'h8000_00F0, 32'h4, 32'hF800_000F, 0, 0, 0);
        do_op(XOR,  32'h8000_00F0, 32'h4, 32'h8000_00F4, 0, 0, 0);
        do_op(OR,   32'h8000_00F0, 32'h4, 32'h8000_00F4, 0, 0, 0);
        do_op(AND,  32'h8000_00F0, 32'h4, 32'h0000_0000, 0, 0, 0);
        do_op(CMPS, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1, 0, 0);
        do_op(CMPU, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 0, 0, 0);
        do_op(CMPS, 32'd5, 32'd5, 32'd5, 0, 1, 0);
        do_op(MUL,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0, 0, 0);
        do_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0);
        do_op(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
        do_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 0);
        do_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(DIVU, 32'd100, 32'd7, 32'd14, 0, 0, 0);
        do_op(REMU, 32'd100, 32'd7, 32'd2, 0, 0, 0);
        do_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
        do_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
        do_op(DIV,  32'd9, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
        do_op(REM,  32'd9, 32'd0, 32'd9, 0, 0, 0);
        do_op(DIVU, 32'd1000, 32'd3, 32'd333, 0, 0, 10);

        // Reset in the middle of a multiply
        op = MUL; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_calc_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_hi_in_ready", in_ready, 0);
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        do_op(MUL, 32'd6, 32'd7, 32'd42, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            ro = 5'($urandom_range(0, 31));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = '0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = $urandom_range(0, 15);
                3: rx = $urandom_range(0, 255);
                4: ry = rx;
                default: ;
            endcase
            do_rand(ro, rx, ry, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
